// File: rtl/pn_pkg.sv
// pn_pkg: shared types and defaults for the PN burst sequencer.
// FSM state enum plus default LFSR width, taps and length width.
package pn_pkg;

  typedef enum logic [1:0] {
    PN_IDLE,
    PN_RUN,
    PN_DONE
  } pn_state_t;

  localparam int PN_N = 4;
  localparam logic [PN_N-1:0] PN_TAP_MASK = 4'b1100;
  localparam int PN_LEN_W = 16;

endpackage

// File: rtl/pn_burst_ctrl_if.sv
// pn_burst_ctrl_if: command and chip-stream handshakes of the burst sequencer.
// master = command source / chip consumer, slave = sequencer.
interface pn_burst_ctrl_if #(
  parameter int N     = 4,
  parameter int LEN_W = 16
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [N-1:0]     cmd_seed;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             chip_valid;
  logic             chip_ready;
  logic             chip_data;
  logic             chip_last;

  modport master (
    output cmd_valid, cmd_seed, cmd_len, abort, chip_ready,
    input  cmd_ready, chip_valid, chip_data, chip_last
  );

  modport slave (
    input  cmd_valid, cmd_seed, cmd_len, abort, chip_ready,
    output cmd_ready, chip_valid, chip_data, chip_last
  );

endinterface

// File: rtl/pn_lfsr_core.sv
// pn_lfsr_core: loadable Fibonacci LFSR, shifts left, feedback into bit 0.
// load has priority over step; resets to all ones.
module pn_lfsr_core #(
  parameter int            N        = 4,
  parameter logic [N-1:0]  TAP_MASK = 4'b1100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         step,
  output logic [N-1:0] state
);

  logic [N-1:0] next;

  assign next = {state[N-2:0], ^(state & TAP_MASK)};

  // state register: load a seed or advance one chip
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '1;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= next;
    end
  end

endmodule

// File: rtl/pn_burst_ctrl.sv
// pn_burst_ctrl: command-driven burst sequencer around pn_lfsr_core.
// Optional macro PN_BURST_WRAP_DET_EN enables the seed-return (wrap) pulse.
module pn_burst_ctrl
  import pn_pkg::*;
#(
  parameter int           N        = PN_N,
  parameter logic [N-1:0] TAP_MASK = PN_TAP_MASK,
  parameter int           LEN_W    = PN_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  pn_burst_ctrl_if.slave   bus,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             seed_err,
  output logic             wrap
);

  pn_state_t        state_q;
  pn_state_t        state_d;
  logic [LEN_W-1:0] remaining_q;
  logic             aborted_q;
  logic             seed_err_q;
  logic [N-1:0]     lfsr_state;
  logic [N-1:0]     eff_seed;
  logic             seed_zero;
  logic             accept;
  logic             step;
  logic             cmd_ready;
  logic             chip_valid;
  logic             chip_last;

  assign seed_zero = (bus.cmd_seed == '0);
  assign eff_seed  = seed_zero ? '1 : bus.cmd_seed;
  assign accept    = (state_q == PN_IDLE) && bus.cmd_valid;
  assign step      = (state_q == PN_RUN) && bus.chip_ready;

  pn_lfsr_core #(
    .N        (N),
    .TAP_MASK (TAP_MASK)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .seed  (eff_seed),
    .step  (step),
    .state (lfsr_state)
  );

  // next-state and handshake outputs; abort wins over the last-chip exit
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    chip_valid = 1'b0;
    chip_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      PN_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          state_d = (bus.cmd_len == '0) ? PN_DONE : PN_RUN;
        end
      end
      PN_RUN: begin
        chip_valid = 1'b1;
        busy       = 1'b1;
        chip_last  = (remaining_q == LEN_W'(1));
        if (bus.abort || (bus.chip_ready && chip_last)) begin
          state_d = PN_DONE;
        end
      end
      PN_DONE: begin
        done    = 1'b1;
        state_d = PN_IDLE;
      end
      default: state_d = PN_IDLE;
    endcase
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.chip_valid = chip_valid;
  assign bus.chip_last  = chip_last;
  assign bus.chip_data  = chip_valid & lfsr_state[N-1];
  assign aborted        = done & aborted_q;
  assign seed_err       = seed_err_q;

  // FSM, chip counter and the registered status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PN_IDLE;
      remaining_q <= '0;
      aborted_q   <= 1'b0;
      seed_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      aborted_q  <= (state_q == PN_RUN) && bus.abort;
      seed_err_q <= accept && seed_zero;
      if (accept) begin
        remaining_q <= bus.cmd_len;
      end else if (step) begin
        remaining_q <= remaining_q - LEN_W'(1);
      end
    end
  end

`ifdef PN_BURST_WRAP_DET_EN
  logic [N-1:0] seed_q;
  logic [N-1:0] lfsr_next;

  assign lfsr_next = {lfsr_state[N-2:0], ^(lfsr_state & TAP_MASK)};
  assign wrap      = step && (lfsr_next == seed_q);

  // keep the effective seed so a full period can be recognised
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed_q <= '1;
    end else if (accept) begin
      seed_q <= eff_seed;
    end
  end
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_pn_burst_ctrl.sv
// tb_pn_burst_ctrl: randomized scoreboard bench for pn_burst_ctrl.
// Expected chips come from an arithmetic PN model, checked by a monitor.
module tb_pn_burst_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic busy, done, aborted, seed_err, wrap;

  always #5 clk = ~clk;

  pn_burst_ctrl_if #(.N(4), .LEN_W(16)) bus ();

  pn_burst_ctrl #(
    .N        (4),
    .TAP_MASK (4'b1100),
    .LEN_W    (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .seed_err (seed_err),
    .wrap     (wrap)
  );

  typedef struct {
    logic data;
    logic last;
    logic wrp;
  } chip_t;

  typedef struct {
    logic serr;
    logic zlen;
  } cmd_t;

  chip_t chip_q[$];
  logic  done_q[$];
  cmd_t  cmd_q[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: chips of a burst from the PN recurrence on an integer state.
  function automatic void model(input int seed, input int len, input int ndel);
    int s;
    int s0;
    int nx;
    s  = (seed == 0) ? 15 : seed;
    s0 = s;
    for (int i = 0; i < ndel; i++) begin
      chip_t c;
      c.data = s[3];
      nx = ((s * 2) % 16) + ($countones(s & 12) % 2);
      c.last = (i == len - 1);
`ifdef PN_BURST_WRAP_DET_EN
      c.wrp = (nx == s0);
`else
      c.wrp = 1'b0;
`endif
      chip_q.push_back(c);
      s = nx;
    end
  endfunction

  bit   acc_prev  = 1'b0;
  bit   done_prev = 1'b0;
  cmd_t cur;

  always @(negedge clk) begin
    if (reset || !mon_en) begin
      acc_prev  = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (acc_prev) begin
        chk("seed_err", seed_err, cur.serr);
        chk("zero_len_done", done, cur.zlen);
        chk("first_valid", bus.chip_valid, !cur.zlen);
        chk("busy_start", busy, !cur.zlen);
      end else begin
        chk("seed_err_quiet", seed_err, 0);
      end
      if (done_prev) chk("cmd_ready_after_done", bus.cmd_ready, 1);
      if (bus.chip_valid) begin
        if (chip_q.size() == 0) begin
          if (bus.chip_ready) chk("chip_unexpected", 1, 0);
        end else begin
          chk("chip_data", bus.chip_data, chip_q[0].data);
          chk("chip_last", bus.chip_last, chip_q[0].last);
          if (bus.chip_ready) begin
            chk("wrap", wrap, chip_q[0].wrp);
            void'(chip_q.pop_front());
          end else begin
            chk("wrap_stall", wrap, 0);
          end
        end
      end else begin
        chk("wrap_idle", wrap, 0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("aborted", aborted, done_q.pop_front());
          chk("cmd_ready_in_done", bus.cmd_ready, 0);
          chk("busy_in_done", busy, 0);
        end
      end else begin
        chk("aborted_quiet", aborted, 0);
      end
      done_prev = done;
      acc_prev  = bus.cmd_valid && bus.cmd_ready;
      if (acc_prev) begin
        if (cmd_q.size() != 0) cur = cmd_q.pop_front();
        else chk("cmd_unexpected", 1, 0);
      end
    end
  end

  task automatic issue_cmd(input logic [3:0] seed, input int len);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_seed  = seed;
    bus.cmd_len   = 16'(len);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // rmode: 0 ready always, 1 pattern 1,0,0 repeating, 2 random
  task automatic run_burst(input logic [3:0] seed, input int len,
                           input int abort_at, input bit simul,
                           input int rmode);
    int  acc;
    int  cyc;
    bit  seen;
    logic r;
    cmd_t c;
    c.serr = (seed == 4'd0);
    c.zlen = (len == 0);
    cmd_q.push_back(c);
    model(int'(seed), len, (abort_at >= 0) ? abort_at : len);
    done_q.push_back(abort_at >= 0);
    issue_cmd(seed, len);
    acc  = 0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      bus.abort = 1'b0;
      unique case (rmode)
        0:       r = 1'b1;
        1:       r = ((cyc % 3) == 0);
        default: r = 1'($urandom_range(1, 0));
      endcase
      if (abort_at >= 0) begin
        if (acc == abort_at) begin
          bus.abort = 1'b1;
          r = 1'b0;
        end else if (simul && acc == abort_at - 1 && r) begin
          bus.abort = 1'b1;
        end
      end
      bus.chip_ready = r;
      @(negedge clk);
      if (bus.chip_valid && bus.chip_ready) acc++;
      if (done) seen = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.abort      = 1'b0;
    bus.chip_ready = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int len;
    int ab;
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_seed   = '0;
    bus.cmd_len    = '0;
    bus.abort      = 1'b0;
    bus.chip_ready = 1'b0;
    #23;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_chip_valid", bus.chip_valid, 0);
    chk("rst_chip_data", bus.chip_data, 0);
    chk("rst_chip_last", bus.chip_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_seed_err", seed_err, 0);
    chk("rst_wrap", wrap, 0);
    mon_en = 1'b1;

    run_burst(4'hf, 8, -1, 1'b0, 0);
    run_burst(4'hf, 8, -1, 1'b0, 1);
    run_burst(4'h0, 3, -1, 1'b0, 0);
    run_burst(4'h5, 0, -1, 1'b0, 0);
    run_burst(4'hf, 10, 3, 1'b0, 0);
    run_burst(4'h6, 5, -1, 1'b0, 0);
    run_burst(4'hf, 16, -1, 1'b0, 0);
    run_burst(4'h9, 10, 4, 1'b1, 2);
    run_burst(4'h3, 6, 0, 1'b0, 2);
    run_burst(4'h1, 40, -1, 1'b0, 2);

    for (int i = 0; i < 25; i++) begin
      len = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(40, 1));
      ab  = -1;
      if (len > 0 && $urandom_range(3, 0) == 0) ab = int'($urandom_range(len - 1, 0));
      run_burst(4'($urandom_range(15, 0)), len, ab,
                (ab >= 1) && ($urandom_range(1, 0) == 1),
                int'($urandom_range(2, 0)));
    end

    cmd_q.push_back('{serr: 1'b0, zlen: 1'b0});
    model(15, 8, 8);
    issue_cmd(4'hf, 8);
    bus.chip_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_mid_chip_valid", bus.chip_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chip_q.delete();
    bus.chip_ready = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rel_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rel_done", done, 0);
    repeat (3) @(negedge clk);
    run_burst(4'ha, 4, -1, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("chip_q_empty", chip_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("cmd_q_empty", cmd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pn_burst_ctrl.md
# pn_burst_ctrl

Command-driven sequencer for the Fibonacci PN generator. Accepts a burst command (seed, chip count) over a valid/ready handshake, loads the LFSR and streams exactly that many chips to a downstream consumer with backpressure. It then signals completion. It sits between the modulator's control logic and the spreading datapath and is the only agent that loads or advances the LFSR.

## Interface
- N, 4, LFSR width (≥2)
- TAP_MASK, 4'b1100, feedback taps; feedback = XOR of (state & TAP_MASK)
- LEN_W, 16, width of chip-count field
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  asynchronous, active-high; all state cleared immediately
- cmd_valid  in  1  burst command present
- cmd_ready  out  1  controller can accept a command
- cmd_seed  in  N  initial LFSR state
- cmd_len  in  LEN_W  number of chips to emit (0 legal)
- abort  in  1  terminate current burst
- chip_valid  out  1  chip_data valid
- chip_ready  in  1  consumer accepts chip
- chip_data  out  1  current chip = state[N-1]
- chip_last  out  1  final chip of burst
- busy  out  1  burst in progress (state RUN)
- done  out  1  one-cycle completion pulse
- aborted  out  1  qualifies done: burst ended by abort
- seed_err  out  1  one-cycle pulse: all-zero seed substituted
- wrap  out  1  one-cycle pulse: LFSR returned to seed (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE, LFSR state = all ones, remaining = 0.
- IDLE: cmd_ready=1. On cmd_valid: latch seed (all-zero seed → all ones, seed_err=1 next cycle), latch remaining=cmd_len. If cmd_len==0 → DONE, else → RUN.
- RUN: chip_valid=1, chip_data=state[N-1], chip_last=(remaining==1). On chip_valid&&chip_ready: state ← {state[N-2:0], ^(state&TAP_MASK)}, remaining ← remaining−1. If chip_last is accepted → DONE.
- DONE: done=1 for exactly one cycle, aborted per cause, → IDLE.
- abort: honoured only in RUN. It has priority over the handshake for state transition. A chip handshaken in the same cycle counts as delivered. → DONE with aborted=1. abort is ignored in IDLE and DONE.
- chip_data/chip_last stay stable while chip_valid && !chip_ready.
- Counter arithmetic is unsigned LEN_W. remaining never underflows; bursts up to 2^LEN_W−1 chips.

## Timing
- Command accepted at edge T → chip_valid high after T (first chip visible in cycle T+1). seed_err is also high in cycle T+1.
- Throughput 1 chip/clock with chip_ready held high.
- Last chip accepted at edge T → done high in cycle T+1, cmd_ready high in cycle T+2.
- cmd_len==0 accepted at T → done in T+1, no chip_valid.
- Reset values: cmd_ready=1 once reset deasserts (IDLE). All other outputs 0.
- Reset mid-burst: outputs drop in the same cycle (async). The burst is discarded, with no done pulse.

## Configuration
- PN_BURST_WRAP_DET_EN defined: store the latched seed. Pulse wrap for one cycle coincident with the accepted chip whose next state equals the stored seed, i.e. after each full period. This repeats for long bursts.
- Undefined: no seed register or comparator. wrap is tied to 0; the port remains for interface stability.

## Structure
- Shared package pn_pkg: FSM state enum (PN_IDLE, PN_RUN, PN_DONE), default N and TAP_MASK constants.
- One sub-module, pn_lfsr_core: loadable LFSR with load, seed and step-enable inputs and a state output. pn_burst_ctrl drives load on command accept and step on chip handshake.

## Test plan
All scenarios use N=4, TAP_MASK=1100; the period is 15.
- Seed 1111, len 8, chip_ready=1 → chips 1,1,1,1,0,0,0,1; chip_last on the 8th; done the next cycle; cmd_ready the cycle after.
- Same command with chip_ready toggling 1,0,0,1,… → identical chip order; data and last held stable during stalls; done only after the 8th accept.
- Seed 0000, len 3 → seed_err pulse in cycle T+1; chips 1,1,1 (treated as seed 1111).
- len 0 → no chip_valid; done in T+1 with aborted=0.
- Seed 1111, len 10, abort asserted after the 3rd accept → done with aborted=1; a next command is accepted 2 cycles later starting from its new seed.
- With PN_BURST_WRAP_DET_EN: seed 1111, len 16 → wrap pulse on the 15th accept; 16th chip =1. Without the macro, wrap stays 0.
- Reset asserted during RUN → chip_valid and busy drop immediately; no done; cmd_ready=1 after release.
